inner_inner_delay_unit: RTL and testbench
=========================================

Name: inner_inner_delay_unit

Overview:
- Two independent, lossless ready/valid delay lanes (lane 0 and lane 1), each carrying a 5-bit payload.
- Each lane is a fixed-depth elastic pipeline: a token accepted on INPUT_k appears on OUTPUT_k exactly DEPTH cycles later when unstalled; lanes never exchange data.
- It is the innermost leaf of the delay-unit hierarchy; parent wrappers only re-route lanes.

Parameters:
- WIDTH, 5, payload width per lane.
- DEPTH, 3, pipeline stages per lane (= unstalled latency in cycles); DEPTH >= 1.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- ASYNCRESET  input  1  reset, asynchronous, active-high.
- INPUT_0_data  input  WIDTH  lane 0 payload in.
- INPUT_0_ready  output  1  lane 0 can accept.
- INPUT_0_valid  input  1  lane 0 payload valid.
- INPUT_1_data  input  WIDTH  lane 1 payload in.
- INPUT_1_ready  output  1  lane 1 can accept.
- INPUT_1_valid  input  1  lane 1 payload valid.
- OUTPUT_0_data  output  WIDTH  lane 0 payload out.
- OUTPUT_0_ready  input  1  lane 0 downstream accepts.
- OUTPUT_0_valid  output  1  lane 0 payload valid.
- OUTPUT_1_data  output  WIDTH  lane 1 payload out.
- OUTPUT_1_ready  input  1  lane 1 downstream accepts.
- OUTPUT_1_valid  output  1  lane 1 payload valid.

Behaviour:
- Per lane state: DEPTH stages, each holding a valid bit v[i] and a data register d[i]; stage DEPTH-1 drives OUTPUT_k_valid/data directly (registered outputs).
- Stage i readiness: r[DEPTH-1] = !v[DEPTH-1] | OUTPUT_k_ready; r[i] = !v[i] | r[i+1].
- INPUT_k_ready = r[0]. This is combinational from OUTPUT_k_ready, giving full throughput of 1 token/cycle/lane with no bubbles.
- On each rising edge, for every stage i with r[i]=1, stage i loads from its predecessor:
  - i=0 loads v=INPUT_k_valid, d=INPUT_k_data.
  - i>0 loads v[i-1], d[i-1].
- Stages with r[i]=0 hold their contents.
- Handshake: input transfer when INPUT_k_valid & INPUT_k_ready; output transfer when OUTPUT_k_valid & OUTPUT_k_ready.
- Latency: a token handshaken in cycle c shows OUTPUT_k_valid=1 with its data in cycle c+DEPTH if OUTPUT_k_ready stays 1.
- Stall: with OUTPUT_k_ready=0, tokens compact forward and fill empty stages. INPUT_k_ready drops only when all DEPTH stages are valid (lane full; capacity DEPTH tokens).
- OUTPUT_k_valid/data are held stable while stalled.
- Full lane with OUTPUT_k_ready=1: the output drains and the input is accepted in the same cycle; occupancy is unchanged.
- Empty lane: OUTPUT_k_valid=0. Data registers load even when valid=0, so output data is don't-care when valid=0.
- Ordering: FIFO per lane; no loss, no duplication.
- Lanes are fully independent; a stall on lane 0 never affects lane 1 and vice versa.
- Reset: asserting ASYNCRESET immediately clears all v[] and d[] to 0 without waiting for a clock edge. This discards in-flight tokens mid-operation.
  - While reset is held: OUTPUT_k_valid=0, OUTPUT_k_data=0, INPUT_k_ready=1.
  - No transfer is captured while reset is held.
  - After deassertion, the first accepted edge is the first rising edge with ASYNCRESET=0.

Decomposition:
- Shared package: WIDTH/DEPTH defaults, data_t (logic [WIDTH-1:0]), stage struct {valid, data}.
- One sub-module, delay_lane (single lane, parameterised WIDTH/DEPTH). It is instantiated twice, INPUT_0→OUTPUT_0 and INPUT_1→OUTPUT_1.

Test Plan:
- Reset check: assert ASYNCRESET mid-stream with tokens in both lanes. Required response, asynchronously without a clock edge: OUTPUT_0/1_valid=0, data=0, INPUT_0/1_ready=1; no stale token appears after release.
- Latency: single token INPUT_0_data=5'h15, valid for cycle c, OUTPUT_0_ready=1 → OUTPUT_0_valid=1, data=5'h15 in cycle c+3 only. Same on lane 1 with 5'h0A.
- Throughput: back-to-back lane 1 tokens 1,2,…,10 with OUTPUT_1_ready=1 → outputs 1..10 on consecutive cycles starting 3 cycles after the first; INPUT_1_ready stays 1.
- Backpressure: OUTPUT_0_ready=0, push 4 tokens → 3 accepted, then INPUT_0_ready=0 and OUTPUT_0 holds the first token. Release ready → tokens drain in order and the 4th is accepted the same cycle ready returns.
- Independence: stall lane 0 indefinitely while streaming lane 1 → lane 1 unaffected; lane 0 data not corrupted.
- Randomized valid/ready on both lanes with a scoreboard → per-lane in-order delivery, no loss or duplicates, outputs stable while stalled.

Source files
------------

// File: rtl/inner_inner_delay_unit_pkg.sv
// Shared types and defaults for the innermost two-lane delay unit.
// Every lane carries data_t payloads through DEPTH elastic stages.
package inner_inner_delay_unit_pkg;

   localparam int WIDTH = 5;
   localparam int DEPTH = 3;

   typedef logic [WIDTH-1:0] data_t;

   typedef struct packed {
      logic  valid;
      data_t data;
   } stage_t;

endpackage

// File: rtl/inner_inner_delay_unit_if.sv
// Ready/valid channel carrying one lane's payload.
// The master drives data/valid and the slave drives ready.
interface inner_inner_delay_unit_if;
   import inner_inner_delay_unit_pkg::*;

   data_t data;
   logic  valid;
   logic  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/inner_inner_delay_unit_delay_lane.sv
// One lossless elastic delay lane: DEPTH stages with registered outputs.
// A stage advances whenever any stage downstream of it has room.
module delay_lane #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [DEPTH-1:0] stage_ready;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic             ready_acc;

   // Accumulate readiness from the output end so no signal depends on itself.
   always_comb begin
      ready_acc   = out_ready;
      stage_ready = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         ready_acc      = ready_acc | ~valid_q[i];
         stage_ready[i] = ready_acc;
      end
   end

   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < DEPTH; i++) begin
         data_d[i] = data_q[i];
      end
      if (stage_ready[0]) begin
         valid_d[0] = in_valid;
         data_d[0]  = in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (stage_ready[i]) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign in_ready  = stage_ready[0];
   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/inner_inner_delay_unit.sv
// Innermost delay unit: two independent elastic delay lanes, 0->0 and 1->1.
module inner_inner_delay_unit
   import inner_inner_delay_unit_pkg::*;
(
   input logic                      CLK,
   input logic                      ASYNCRESET,
   inner_inner_delay_unit_if.slave  INPUT_0,
   inner_inner_delay_unit_if.slave  INPUT_1,
   inner_inner_delay_unit_if.master OUTPUT_0,
   inner_inner_delay_unit_if.master OUTPUT_1
);

   delay_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lane_0 (
      .clk       (CLK),
      .rst       (ASYNCRESET),
      .in_data   (INPUT_0.data),
      .in_valid  (INPUT_0.valid),
      .in_ready  (INPUT_0.ready),
      .out_data  (OUTPUT_0.data),
      .out_valid (OUTPUT_0.valid),
      .out_ready (OUTPUT_0.ready)
   );

   delay_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lane_1 (
      .clk       (CLK),
      .rst       (ASYNCRESET),
      .in_data   (INPUT_1.data),
      .in_valid  (INPUT_1.valid),
      .in_ready  (INPUT_1.ready),
      .out_data  (OUTPUT_1.data),
      .out_valid (OUTPUT_1.valid),
      .out_ready (OUTPUT_1.ready)
   );

endmodule

// File: tb/tb_inner_inner_delay_unit.sv
// Scoreboard bench: each lane is modelled as a FIFO of (payload, accept cycle).
// A token may only be at the head of the output DEPTH cycles after acceptance.
module tb_inner_inner_delay_unit;
   import inner_inner_delay_unit_pkg::*;

   typedef struct {
      data_t data;
      int    t;
   } tok_t;

   logic CLK = 1'b0;
   logic ASYNCRESET;

   inner_inner_delay_unit_if in0 ();
   inner_inner_delay_unit_if in1 ();
   inner_inner_delay_unit_if out0 ();
   inner_inner_delay_unit_if out1 ();

   inner_inner_delay_unit dut (
      .CLK        (CLK),
      .ASYNCRESET (ASYNCRESET),
      .INPUT_0    (in0),
      .INPUT_1    (in1),
      .OUTPUT_0   (out0),
      .OUTPUT_1   (out1)
   );

   always #5 CLK = ~CLK;

   logic  in_valid_r  [2];
   data_t in_data_r   [2];
   logic  out_ready_r [2];

   assign in0.valid  = in_valid_r[0];
   assign in0.data   = in_data_r[0];
   assign in1.valid  = in_valid_r[1];
   assign in1.data   = in_data_r[1];
   assign out0.ready = out_ready_r[0];
   assign out1.ready = out_ready_r[1];

   logic [1:0] in_ready_w;
   logic [1:0] out_valid_w;
   data_t      out_data_w [2];

   assign in_ready_w[0]  = in0.ready;
   assign in_ready_w[1]  = in1.ready;
   assign out_valid_w[0] = out0.valid;
   assign out_valid_w[1] = out1.valid;
   assign out_data_w[0]  = out0.data;
   assign out_data_w[1]  = out1.data;

   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   tok_t exp_q [2][$];
   logic in_fire    [2];
   logic stall_prev [2];
   data_t prev_data [2];
   int   occ;
   logic exp_valid;
   tok_t tok;

   always @(posedge CLK) cycle <= cycle + 1;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cycle, actual, expected);
      end
   endtask

   // Monitor: compares the DUT against the lane FIFO model every cycle.
   always @(negedge CLK) begin
      if (!ASYNCRESET) begin
         for (int l = 0; l < 2; l++) begin
            occ       = exp_q[l].size();
            exp_valid = (occ > 0) && (cycle >= exp_q[l][0].t + DEPTH);
            check_output($sformatf("lane%0d in_ready", l), int'(in_ready_w[l]),
                         int'((occ < DEPTH) || out_ready_r[l]));
            check_output($sformatf("lane%0d out_valid", l), int'(out_valid_w[l]), int'(exp_valid));
            if (stall_prev[l]) begin
               check_output($sformatf("lane%0d stall hold", l), int'(out_data_w[l]), int'(prev_data[l]));
            end
            if (out_valid_w[l] && out_ready_r[l] && occ > 0) begin
               tok = exp_q[l].pop_front();
               check_output($sformatf("lane%0d out_data", l), int'(out_data_w[l]), int'(tok.data));
            end
            in_fire[l] = in_valid_r[l] && in_ready_w[l];
            if (in_fire[l]) begin
               tok.data = in_data_r[l];
               tok.t    = cycle;
               exp_q[l].push_back(tok);
            end
            stall_prev[l] = out_valid_w[l] && !out_ready_r[l];
            prev_data[l]  = out_data_w[l];
         end
      end else begin
         for (int l = 0; l < 2; l++) begin
            in_fire[l]    = 1'b0;
            stall_prev[l] = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, " out0 valid"}, int'(out0.valid), 0);
      check_output({tag, " out0 data"},  int'(out0.data), 0);
      check_output({tag, " in0 ready"},  int'(in0.ready), 1);
      check_output({tag, " out1 valid"}, int'(out1.valid), 0);
      check_output({tag, " out1 data"},  int'(out1.data), 0);
      check_output({tag, " in1 ready"},  int'(in1.ready), 1);
   endtask

   // Holds valid until the token is taken; leaves valid asserted on return.
   task automatic apply_stimulus(input int lane, input data_t value, output int waits);
      in_valid_r[lane] = 1'b1;
      in_data_r[lane]  = value;
      waits = 0;
      do begin
         step();
         waits++;
      end while (!in_fire[lane] && waits < 64);
      if (!in_fire[lane]) check_output($sformatf("lane%0d send timeout", lane), 0, 1);
   endtask

   int waits;

   initial begin
      for (int l = 0; l < 2; l++) begin
         in_valid_r[l]  = 1'b0;
         in_data_r[l]   = '0;
         out_ready_r[l] = 1'b1;
         in_fire[l]     = 1'b0;
         stall_prev[l]  = 1'b0;
         prev_data[l]   = '0;
      end
      ASYNCRESET = 1'b1;
      #1;
      check_reset_outputs("power-on reset");
      repeat (2) @(posedge CLK);
      #3;
      ASYNCRESET = 1'b0;
      step();

      // Single-token latency on each lane.
      apply_stimulus(0, 5'h15, waits);
      in_valid_r[0] = 1'b0;
      repeat (6) step();
      apply_stimulus(1, 5'h0A, waits);
      in_valid_r[1] = 1'b0;
      repeat (6) step();

      // Back-to-back stream on lane 1.
      for (int v = 1; v <= 10; v++) begin
         apply_stimulus(1, data_t'(v), waits);
         check_output("throughput accept wait", waits, 1);
      end
      in_valid_r[1] = 1'b0;
      repeat (6) step();

      // Backpressure: fill lane 0, then release.
      out_ready_r[0] = 1'b0;
      for (int v = 1; v <= 3; v++) begin
         apply_stimulus(0, data_t'(v + 16), waits);
         check_output("fill accept wait", waits, 1);
      end
      in_valid_r[0] = 1'b1;
      in_data_r[0]  = 5'h14;
      repeat (3) step();
      check_output("full in0 ready", int'(in0.ready), 0);
      check_output("full out0 valid", int'(out0.valid), 1);
      check_output("full out0 data", int'(out0.data), 17);
      out_ready_r[0] = 1'b1;
      apply_stimulus(0, 5'h14, waits);
      check_output("release accept wait", waits, 1);
      in_valid_r[0] = 1'b0;
      repeat (6) step();

      // Independence: lane 0 stalled full while lane 1 streams.
      out_ready_r[0] = 1'b0;
      for (int v = 0; v < 3; v++) apply_stimulus(0, data_t'(v + 5), waits);
      in_valid_r[0] = 1'b1;
      in_data_r[0]  = 5'h1F;
      for (int v = 0; v < 20; v++) begin
         apply_stimulus(1, data_t'($urandom), waits);
         check_output("indep lane1 accept wait", waits, 1);
      end
      in_valid_r[1] = 1'b0;
      check_output("indep in0 ready", int'(in0.ready), 0);
      check_output("indep out0 data", int'(out0.data), 5);
      out_ready_r[0] = 1'b1;
      apply_stimulus(0, 5'h1F, waits);
      in_valid_r[0] = 1'b0;
      repeat (6) step();

      // Asynchronous reset with tokens in flight on both lanes.
      out_ready_r[0] = 1'b0;
      out_ready_r[1] = 1'b0;
      apply_stimulus(0, 5'h0C, waits);
      apply_stimulus(1, 5'h0D, waits);
      apply_stimulus(0, 5'h0E, waits);
      apply_stimulus(1, 5'h0F, waits);
      repeat (3) step();
      @(posedge CLK);
      #3;
      ASYNCRESET = 1'b1;
      #1;
      check_reset_outputs("mid-stream reset");
      exp_q[0].delete();
      exp_q[1].delete();
      out_ready_r[0] = 1'b1;
      out_ready_r[1] = 1'b1;
      repeat (3) begin
         step();
         check_reset_outputs("held reset");
      end
      @(posedge CLK);
      #3;
      in_valid_r[0] = 1'b0;
      in_valid_r[1] = 1'b0;
      ASYNCRESET    = 1'b0;
      repeat (6) step();

      // Randomised valid/ready on both lanes.
      for (int n = 0; n < 800; n++) begin
         for (int l = 0; l < 2; l++) begin
            if (!in_valid_r[l] || in_fire[l]) begin
               in_valid_r[l] = ($urandom_range(0, 99) < 60);
               in_data_r[l]  = data_t'($urandom);
            end
            out_ready_r[l] = ($urandom_range(0, 99) < ((n % 200 < 40) ? 15 : 65));
         end
         step();
      end

      // Drain and confirm nothing was lost.
      in_valid_r[0]  = 1'b0;
      in_valid_r[1]  = 1'b0;
      out_ready_r[0] = 1'b1;
      out_ready_r[1] = 1'b1;
      repeat (DEPTH + 4) step();
      check_output("lane0 drained", exp_q[0].size(), 0);
      check_output("lane1 drained", exp_q[1].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
